// File: rtl/wide_word_serializer.sv
// wide_word_serializer
//   Accepts one wide word per valid/ready transfer and emits it as a stream of
//   OUT_WIDTH-bit beats, least-significant chunk first, flagging the final beat.
//   A new word can be loaded on the cycle the last beat transfers, so words
//   stream with no bubble between them.
//
// Ports
//   clk      in   sole clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_valid  in   wide word offered
//   i_ready  out  word accepted this cycle (combinational from o_ready on last beat)
//   i_data   in   wide word, sampled on i_valid && i_ready
//   o_valid  out  beat valid
//   o_ready  in   downstream accepts the beat
//   o_data   out  current beat
//   o_last   out  final beat of the word
module wide_word_serializer #(
    parameter int unsigned IN_WIDTH  = 1024,
    parameter int unsigned OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [IN_WIDTH-1:0]  i_data,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_last
);

    localparam int unsigned BEATS = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BEATS - 1);

    if (((IN_WIDTH % OUT_WIDTH) != 0) || (BEATS < 2)) begin : g_bad_params
        $fatal(1, "wide_word_serializer: IN_WIDTH must be a multiple of OUT_WIDTH, >= 2 beats");
    end

    typedef enum logic {StIdle, StSend} state_e;

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;

        o_valid = (state_q == StSend);
        o_data  = shift_q[OUT_WIDTH-1:0];
        o_last  = o_valid && (cnt_q == LastBeat);
        // Accept a new word when idle, or as the last beat leaves so words abut.
        i_ready = !o_valid || (o_last && o_ready);
        load    = i_valid && i_ready;

        case (state_q)
            StIdle: begin
                if (load) begin
                    shift_d = i_data;
                    cnt_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (o_ready) begin
                    if (!o_last) begin
                        shift_d = shift_q >> OUT_WIDTH;
                        cnt_d   = cnt_q + 1'b1;
                    end else if (load) begin
                        shift_d = i_data;
                        cnt_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_wide_word_serializer.sv
module tb_wide_word_serializer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          i_ready;
    logic [1023:0] i_data;
    logic          o_valid;
    logic          o_ready;
    logic [31:0]   o_data;
    logic          o_last;

    logic          s_i_valid;
    logic          s_i_ready;
    logic [63:0]   s_i_data;
    logic          s_o_valid;
    logic          s_o_ready;
    logic [15:0]   s_o_data;
    logic          s_o_last;

    int errors = 0;
    int checks = 0;
    int beats_seen = 0;

    logic [32:0] exp_q[$];
    logic [16:0] s_exp_q[$];

    bit          toggle_mode = 0;
    int          pidx = 0;
    bit [3:0]    pat = 4'b1001;  // o_ready sequence 1,0,0,1 (bit 0 first)

    always #5 clk = ~clk;

    wide_word_serializer #(.IN_WIDTH(1024), .OUT_WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_last  (o_last)
    );

    wide_word_serializer #(.IN_WIDTH(64), .OUT_WIDTH(16)) dut_s (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (s_i_valid),
        .i_ready (s_i_ready),
        .i_data  (s_i_data),
        .o_valid (s_o_valid),
        .o_ready (s_o_ready),
        .o_data  (s_o_data),
        .o_last  (s_o_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1023:0] build(input logic [31:0] base);
        logic [1023:0] w;
        for (int k = 0; k < 32; k++) w[k*32 +: 32] = base + 32'(k);
        return w;
    endfunction

    task automatic push_word(input logic [1023:0] d);
        for (int k = 0; k < 32; k++) exp_q.push_back({(k == 31), d[k*32 +: 32]});
    endtask

    // Offer a word; returns just after the handshake edge with i_valid still high.
    task automatic offer(input logic [1023:0] d);
        bit ok = 0;
        i_data  = d;
        i_valid = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (i_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("offer_timeout", 64'd1, 64'd0);
        end else begin
            @(posedge clk);
            push_word(d);
            #1;
        end
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk(name, 64'(ok), 64'd1);
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        chk({name, "_o_valid"}, 64'(o_valid), 64'd0);
        chk({name, "_i_ready"}, 64'(i_ready), 64'd1);
    endtask

    always @(posedge clk) begin
        #1;
        if (toggle_mode) begin
            o_ready = pat[pidx];
            pidx    = (pidx + 1) % 4;
        end
    end

    // Scoreboard monitor for the wide instance.
    bit          stall = 0;
    logic [31:0] held_d;
    logic        held_l;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 0;
        end else begin
            if (stall) begin
                chk("hold_valid", 64'(o_valid), 64'd1);
                chk("hold_data", 64'({o_last, o_data}), 64'({held_l, held_d}));
            end
            if (o_valid && !o_last) chk("i_ready_mid_word", 64'(i_ready), 64'd0);
            if (o_valid && o_last && o_ready) chk("i_ready_last", 64'(i_ready), 64'd1);
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'({o_last, o_data}), 64'hDEAD);
                end else begin
                    chk("beat", 64'({o_last, o_data}), 64'(exp_q.pop_front()));
                end
                beats_seen++;
            end
            stall  = o_valid && !o_ready;
            held_d = o_data;
            held_l = o_last;
        end
    end

    // Scoreboard monitor for the small instance.
    always @(negedge clk) begin
        if (rst_n && s_o_valid && s_o_ready) begin
            if (s_exp_q.size() == 0) begin
                chk("s_unexpected_beat", 64'({s_o_last, s_o_data}), 64'hDEAD);
            end else begin
                chk("s_beat", 64'({s_o_last, s_o_data}), 64'(s_exp_q.pop_front()));
            end
        end
    end

    initial begin
        int start;
        int cnt;
        bit ok;
        logic [1023:0] wa;
        logic [1023:0] wb;
        wa = build(32'hA000_0000);
        wb = build(32'hB000_0000);

        rst_n     = 1'b0;
        i_valid   = 1'b0;
        i_data    = '0;
        o_ready   = 1'b1;
        s_i_valid = 1'b0;
        s_i_data  = '0;
        s_o_ready = 1'b1;
        #3;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_last", 64'(o_last), 64'd0);
        chk("rst_o_data", 64'(o_data), 64'd0);
        chk("rst_i_ready", 64'(i_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single word, o_ready held high.
        start = beats_seen;
        offer(wa);
        i_valid = 1'b0;
        @(negedge clk);
        chk("latency_o_valid", 64'(o_valid), 64'd1);
        chk("latency_o_data", 64'(o_data), 64'hA000_0000);
        drain("single_drain");
        chk("single_count", 64'(beats_seen - start), 64'd32);
        idle_check("single_idle");

        // Backpressure with o_ready pattern 1,0,0,1.
        @(posedge clk);
        #1;
        start = beats_seen;
        pidx = 0;
        toggle_mode = 1;
        offer(wa);
        i_valid = 1'b0;
        drain("bp_drain");
        #2;
        toggle_mode = 0;
        o_ready = 1'b1;
        chk("bp_count", 64'(beats_seen - start), 64'd32);
        idle_check("bp_idle");

        // Back-to-back words, second held valid throughout the first.
        @(posedge clk);
        #1;
        start = beats_seen;
        offer(wa);
        cnt = 0;
        fork
            begin
                offer(wb);
                i_valid = 1'b0;
            end
            begin
                for (int n = 0; n < 64; n++) begin
                    @(negedge clk);
                    if (o_valid) cnt++;
                end
            end
        join
        chk("b2b_contiguous", 64'(cnt), 64'd64);
        drain("b2b_drain");
        chk("b2b_count", 64'(beats_seen - start), 64'd64);
        idle_check("b2b_idle");

        // Reset after beat 5 of a word.
        @(posedge clk);
        #1;
        start = beats_seen;
        offer(build(32'hC000_0000));
        i_valid = 1'b0;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            if (beats_seen - start == 6) begin
                ok = 1;
                break;
            end
        end
        chk("reset_reach_beat5", 64'(ok), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", 64'(o_valid), 64'd0);
        chk("midrst_i_ready", 64'(i_ready), 64'd1);
        chk("midrst_o_data", 64'(o_data), 64'd0);
        chk("midrst_o_last", 64'(o_last), 64'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("post_rst");
        @(posedge clk);
        #1;
        start = beats_seen;
        offer(build(32'hD000_0000));
        i_valid = 1'b0;
        drain("post_rst_drain");
        chk("post_rst_count", 64'(beats_seen - start), 64'd32);

        // Small parameter instance.
        @(posedge clk);
        #1;
        s_i_data  = 64'h4444_3333_2222_1111;
        s_i_valid = 1'b1;
        @(negedge clk);
        chk("s_i_ready", 64'(s_i_ready), 64'd1);
        @(posedge clk);
        s_exp_q.push_back({1'b0, 16'h1111});
        s_exp_q.push_back({1'b0, 16'h2222});
        s_exp_q.push_back({1'b0, 16'h3333});
        s_exp_q.push_back({1'b1, 16'h4444});
        #1;
        s_i_valid = 1'b0;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            if (s_exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk("s_drain", 64'(ok), 64'd1);
        @(negedge clk);
        chk("s_idle_o_valid", 64'(s_o_valid), 64'd0);

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
